brq_dmem_responder: RTL and testbench
=====================================

# brq_dmem_responder

Data-memory responder for the Buraq-mini core: the slave end of the core's load/store port (`Data_mem_*`, `ldst_byte_en`). It stores words in an on-chip synchronous array and applies sub-word store lane masking. It returns sign- or zero-extended load data one cycle after a read request. Misaligned and unsupported accesses are blocked and flagged. It sits beside the core top level, in place of the external data BRAM on the Arty A7 build.

## Interface
- `DataWidth`, 32: data bus width; only 32 is supported.
- `AddrWidth`, 15: byte-address width. Array depth is the localparam `Depth = 2**(AddrWidth-2)` words.
- `brq_clk`  in  1  single clock; all state updates on the rising edge.
- `brq_rst`  in  1  asynchronous, active-low reset.
- `Data_mem_address`  in  AddrWidth  byte address of the access.
- `Data_mem_dataIn`  in  DataWidth  store data, LSB-aligned (byte in [7:0], half in [15:0]).
- `Data_mem_read_en`  in  1  load request, sampled on the rising edge.
- `Data_mem_write_en`  in  1  store request, sampled on the rising edge.
- `ldst_byte_en`  in  3  size code, equal to RV32 func3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `Data_mem_dataOut`  out  DataWidth  registered, extended load data.
- `dmem_rvalid`  out  1  high for one cycle when `Data_mem_dataOut` carries a new load result.
- `dmem_err`  out  1  sticky flag for a misaligned or unsupported access.
- `dmem_err_addr`  out  AddrWidth  address of the first faulting access.

## Operation
- **Word index** = `Data_mem_address[AddrWidth-1:2]`. **Lane offset** = `Data_mem_address[1:0]`.
- **Legality**
  - W requires offset 00.
  - H/HU require offset[0] = 0.
  - B/BU are always aligned.
  - Codes 011, 110 and 111 are unsupported.
  - 100 and 101 are legal for loads only. A store carrying 100 or 101 is unsupported.
- **Stores** (write_en=1, legal):
  - B writes lane `offset` with dataIn[7:0].
  - H writes lanes {offset[1],0} and {offset[1],1} with dataIn[15:0].
  - W writes all four lanes.
  - Unwritten lanes keep their previous value.
- **Loads** (read_en=1, legal): select the lane(s) as for stores, then:
  - B and H sign-extend from bit 7 or bit 15.
  - BU and HU zero-extend.
  - W passes the word through.
- **Illegal access** (either direction):
  - No array write.
  - For a read, `Data_mem_dataOut` is 0 and `dmem_rvalid` is 1.
  - If `dmem_err` = 0, set it and capture the address into `dmem_err_addr`. If `dmem_err` = 1, leave both unchanged; they clear only on reset.
- **Simultaneous read_en and write_en**
  - The write executes and the read is dropped.
  - `dmem_rvalid` = 0 and `Data_mem_dataOut` holds.
  - This counts as an error event with the current address.
- **Idle** (neither enable): `Data_mem_dataOut` holds its last value and `dmem_rvalid` = 0.
- **Array contents** are not reset and are undefined until written (X in simulation).

## Timing
- **Reset** (brq_rst = 0, asynchronous): `Data_mem_dataOut` = 0, `dmem_rvalid` = 0, `dmem_err` = 0, `dmem_err_addr` = 0.
  - Array writes are suppressed while reset is low.
  - A request in flight when reset asserts is discarded.
  - On the first edge after release, requests are sampled normally.
- **Load latency**: 1 cycle.
  - Request sampled at edge N; data and `dmem_rvalid` are valid from N until N+1.
  - Back-to-back loads give one result per cycle.
- **Store**: committed at the sampling edge; no response signal.
- **Store followed by load**: a load at edge N+1 to a word stored at edge N returns the new data (read-after-write).
- **Store then load to the same word on consecutive edges with different lanes**: the load sees the merged word.
- **Error flag**: `dmem_err` rises in the cycle after the faulting edge.
- **Address wrap**: none. Every index in 0..Depth-1 is valid; the top word sits at byte address 2^AddrWidth - 4.

## Test plan
- **Reset values**: with brq_rst low mid-simulation, all outputs read 0. While reset is low, a SW to 0x10 with dataIn 0xDEADBEEF is applied; after release, LW 0x10 does not return 0xDEADBEEF.
- **Sub-word stores and extension**
  - SW 0x20 ← 0x11223344, then SB 0x21 ← 0x000000F0, then SH 0x22 ← 0x00008001.
  - LW 0x20 → 0x8001F044.
  - LB 0x21 → 0xFFFFFFF0; LBU 0x21 → 0x000000F0.
  - LH 0x22 → 0xFFFF8001; LHU 0x22 → 0x00008001.
- **Latency and throughput**
  - LW to 0x0, 0x4, 0x8 on consecutive cycles: `dmem_rvalid` is high for 3 consecutive cycles, with data in request order.
  - SW 0x30 ← 0xA5A5A5A5 followed immediately by LW 0x30 → 0xA5A5A5A5.
- **Misalignment**
  - LW 0x41 → dataOut 0, rvalid 1, `dmem_err` 1, `dmem_err_addr` 0x41.
  - A following SH 0x43 does not write, and `dmem_err_addr` stays 0x41.
- **Unsupported and collision cases**
  - Store with code 100 to 0x50: array unchanged.
  - Read_en and write_en together (SW 0x54 ← 0x12345678): write done, `dmem_rvalid` 0, `Data_mem_dataOut` unchanged.
- **Top of memory**: SW at 0x7FFC (AddrWidth 15) ← 0xCAFEF00D, then LW 0x7FFC → 0xCAFEF00D, and LW 0x0 is unchanged.

Source files
------------

// File: rtl/brq_dmem_responder.sv
// Data-memory responder for the Buraq-mini load/store port: word array with byte-lane
// store masking, registered sign/zero-extended load data and a sticky access-fault flag.
module brq_dmem_responder #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 15
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic [AddrWidth-1:0] Data_mem_address,
    input  logic [DataWidth-1:0] Data_mem_dataIn,
    input  logic                 Data_mem_read_en,
    input  logic                 Data_mem_write_en,
    input  logic [2:0]           ldst_byte_en,
    output logic [DataWidth-1:0] Data_mem_dataOut,
    output logic                 dmem_rvalid,
    output logic                 dmem_err,
    output logic [AddrWidth-1:0] dmem_err_addr
);
    localparam int Depth = 2**(AddrWidth-2);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [DataWidth-1:0] mem [Depth];

    logic [DataWidth-1:0] dout_q, dout_d;
    logic                 rvalid_q, rvalid_d;
    logic                 err_q, err_d;
    logic [AddrWidth-1:0] err_addr_q, err_addr_d;

    logic [AddrWidth-3:0] idx;
    logic [1:0]           off;
    logic                 legal, do_write, do_read, err_event;
    logic [3:0]           lane_we;
    logic [DataWidth-1:0] wdata, word, load_data;
    logic [7:0]           rbyte;
    logic [15:0]          rhalf;

    assign idx = Data_mem_address[AddrWidth-1:2];
    assign off = Data_mem_address[1:0];

    always_comb begin
        legal = 1'b0;
        case (ldst_byte_en)
            F3_B:    legal = 1'b1;
            F3_H:    legal = ~off[0];
            F3_W:    legal = (off == 2'b00);
            // Unsigned codes only make sense for loads; a store carrying them is a fault.
            F3_BU:   legal = ~Data_mem_write_en;
            F3_HU:   legal = ~Data_mem_write_en & ~off[0];
            default: legal = 1'b0;
        endcase

        do_write  = Data_mem_write_en & legal;
        do_read   = Data_mem_read_en & ~Data_mem_write_en;
        err_event = (Data_mem_read_en | Data_mem_write_en)
                  & (~legal | (Data_mem_read_en & Data_mem_write_en));

        lane_we = 4'b0000;
        wdata   = Data_mem_dataIn;
        case (ldst_byte_en)
            F3_B: begin
                lane_we = 4'b0001 << off;
                wdata   = {4{Data_mem_dataIn[7:0]}};
            end
            F3_H: begin
                lane_we = off[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{Data_mem_dataIn[15:0]}};
            end
            F3_W:    lane_we = 4'b1111;
            default: lane_we = 4'b0000;
        endcase

        word = mem[idx];
        case (off)
            2'd0:    rbyte = word[7:0];
            2'd1:    rbyte = word[15:8];
            2'd2:    rbyte = word[23:16];
            default: rbyte = word[31:24];
        endcase
        rhalf = off[1] ? word[31:16] : word[15:0];

        case (ldst_byte_en)
            F3_B:    load_data = {{24{rbyte[7]}}, rbyte};
            F3_H:    load_data = {{16{rhalf[15]}}, rhalf};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'b0, rbyte};
            F3_HU:   load_data = {16'b0, rhalf};
            default: load_data = '0;
        endcase

        dout_d     = dout_q;
        rvalid_d   = 1'b0;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (do_read) begin
            rvalid_d = 1'b1;
            dout_d   = legal ? load_data : '0;
        end
        if (err_event && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = Data_mem_address;
        end
    end

    // The array lives in the reset block only so that writes are blocked while reset is low;
    // its contents are never cleared.
    always_ff @(posedge brq_clk or negedge brq_rst) begin
        if (!brq_rst) begin
            dout_q     <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            dout_q     <= dout_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            if (do_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (lane_we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign Data_mem_dataOut = dout_q;
    assign dmem_rvalid      = rvalid_q;
    assign dmem_err         = err_q;
    assign dmem_err_addr    = err_addr_q;
endmodule

// File: tb/tb_brq_dmem_responder.sv
// Directed bench for brq_dmem_responder: hand-computed vectors checked with immediate assertions.
module tb_brq_dmem_responder;
    logic        brq_clk = 1'b0;
    logic        brq_rst = 1'b0;
    logic [14:0] Data_mem_address = '0;
    logic [31:0] Data_mem_dataIn = '0;
    logic        Data_mem_read_en = 1'b0;
    logic        Data_mem_write_en = 1'b0;
    logic [2:0]  ldst_byte_en = 3'b010;
    logic [31:0] Data_mem_dataOut;
    logic        dmem_rvalid;
    logic        dmem_err;
    logic [14:0] dmem_err_addr;

    int n_checks = 0;
    int n_pass   = 0;

    brq_dmem_responder #(.DataWidth(32), .AddrWidth(15)) dut (
        .brq_clk(brq_clk), .brq_rst(brq_rst),
        .Data_mem_address(Data_mem_address), .Data_mem_dataIn(Data_mem_dataIn),
        .Data_mem_read_en(Data_mem_read_en), .Data_mem_write_en(Data_mem_write_en),
        .ldst_byte_en(ldst_byte_en), .Data_mem_dataOut(Data_mem_dataOut),
        .dmem_rvalid(dmem_rvalid), .dmem_err(dmem_err), .dmem_err_addr(dmem_err_addr)
    );

    always #5 brq_clk = ~brq_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One request sampled at the next rising edge; outputs are then checked 1ns later.
    task automatic acc(input logic re, input logic we, input logic [2:0] f3,
                       input logic [14:0] a, input logic [31:0] d);
        Data_mem_read_en  = re;
        Data_mem_write_en = we;
        ldst_byte_en      = f3;
        Data_mem_address  = a;
        Data_mem_dataIn   = d;
        @(posedge brq_clk);
        #1;
        Data_mem_read_en  = 1'b0;
        Data_mem_write_en = 1'b0;
    endtask

    task automatic sw(input logic [14:0] a, input logic [31:0] d); acc(1'b0, 1'b1, 3'b010, a, d); endtask
    task automatic ld(input logic [2:0] f3, input logic [14:0] a); acc(1'b1, 1'b0, f3, a, 32'h0); endtask
    task automatic idle(); @(posedge brq_clk); #1; endtask

    initial begin
        repeat (2) @(negedge brq_clk);
        chk("rst_dout0", Data_mem_dataOut, 32'h0);
        chk("rst_rvalid0", {31'b0, dmem_rvalid}, 32'h0);
        brq_rst = 1'b1;
        @(negedge brq_clk);

        sw(15'h0010, 32'h01020304);
        sw(15'h0000, 32'hAAAA0000);
        sw(15'h0004, 32'hBBBB1111);
        sw(15'h0008, 32'hCCCC2222);
        chk("store_no_rvalid", {31'b0, dmem_rvalid}, 32'h0);

        // Back-to-back word loads
        ld(3'b010, 15'h0000);
        chk("lw0_rvalid", {31'b0, dmem_rvalid}, 32'h1);
        chk("lw0_data", Data_mem_dataOut, 32'hAAAA0000);
        ld(3'b010, 15'h0004);
        chk("lw4_rvalid", {31'b0, dmem_rvalid}, 32'h1);
        chk("lw4_data", Data_mem_dataOut, 32'hBBBB1111);
        ld(3'b010, 15'h0008);
        chk("lw8_rvalid", {31'b0, dmem_rvalid}, 32'h1);
        chk("lw8_data", Data_mem_dataOut, 32'hCCCC2222);
        idle();
        chk("idle_rvalid", {31'b0, dmem_rvalid}, 32'h0);
        chk("idle_hold", Data_mem_dataOut, 32'hCCCC2222);

        // Sub-word stores and extension
        sw(15'h0020, 32'h11223344);
        acc(1'b0, 1'b1, 3'b000, 15'h0021, 32'h000000F0);
        acc(1'b0, 1'b1, 3'b001, 15'h0022, 32'h00008001);
        ld(3'b010, 15'h0020); chk("lw20_merged", Data_mem_dataOut, 32'h8001F044);
        ld(3'b000, 15'h0021); chk("lb21", Data_mem_dataOut, 32'hFFFFFFF0);
        ld(3'b100, 15'h0021); chk("lbu21", Data_mem_dataOut, 32'h000000F0);
        ld(3'b001, 15'h0022); chk("lh22", Data_mem_dataOut, 32'hFFFF8001);
        ld(3'b101, 15'h0022); chk("lhu22", Data_mem_dataOut, 32'h00008001);
        ld(3'b000, 15'h0020); chk("lb20", Data_mem_dataOut, 32'h00000044);
        ld(3'b001, 15'h0020); chk("lh20", Data_mem_dataOut, 32'hFFFFF044);

        // Read-after-write on consecutive edges
        sw(15'h0030, 32'hA5A5A5A5);
        ld(3'b010, 15'h0030); chk("raw30", Data_mem_dataOut, 32'hA5A5A5A5);
        chk("err_clean", {31'b0, dmem_err}, 32'h0);

        // Misalignment
        sw(15'h0040, 32'h89ABCDEF);
        ld(3'b010, 15'h0041);
        chk("mis_dout", Data_mem_dataOut, 32'h0);
        chk("mis_rvalid", {31'b0, dmem_rvalid}, 32'h1);
        chk("mis_err", {31'b0, dmem_err}, 32'h1);
        chk("mis_err_addr", {17'b0, dmem_err_addr}, 32'h41);
        acc(1'b0, 1'b1, 3'b001, 15'h0043, 32'h00001111);
        chk("sh43_err_addr_sticky", {17'b0, dmem_err_addr}, 32'h41);
        ld(3'b010, 15'h0040); chk("sh43_no_write", Data_mem_dataOut, 32'h89ABCDEF);

        // Unsupported store code
        sw(15'h0050, 32'h55555555);
        acc(1'b0, 1'b1, 3'b100, 15'h0050, 32'h000000FF);
        ld(3'b010, 15'h0050); chk("st100_no_write", Data_mem_dataOut, 32'h55555555);
        ld(3'b011, 15'h0050);
        chk("ld011_dout0", Data_mem_dataOut, 32'h0);
        chk("ld011_rvalid", {31'b0, dmem_rvalid}, 32'h1);

        // Read/write collision
        ld(3'b010, 15'h0008);
        acc(1'b1, 1'b1, 3'b010, 15'h0054, 32'h12345678);
        chk("coll_rvalid", {31'b0, dmem_rvalid}, 32'h0);
        chk("coll_hold", Data_mem_dataOut, 32'hCCCC2222);
        ld(3'b010, 15'h0054); chk("coll_written", Data_mem_dataOut, 32'h12345678);
        chk("coll_err_addr", {17'b0, dmem_err_addr}, 32'h41);

        // Top of memory
        sw(15'h7FFC, 32'hCAFEF00D);
        ld(3'b010, 15'h7FFC); chk("top_word", Data_mem_dataOut, 32'hCAFEF00D);
        ld(3'b010, 15'h0000); chk("word0_intact", Data_mem_dataOut, 32'hAAAA0000);

        // Asynchronous reset mid-run, with a store applied while reset is low
        ld(3'b010, 15'h0004);
        brq_rst = 1'b0;
        #1;
        chk("arst_dout", Data_mem_dataOut, 32'h0);
        chk("arst_rvalid", {31'b0, dmem_rvalid}, 32'h0);
        chk("arst_err", {31'b0, dmem_err}, 32'h0);
        chk("arst_err_addr", {17'b0, dmem_err_addr}, 32'h0);
        Data_mem_write_en = 1'b1;
        ldst_byte_en      = 3'b010;
        Data_mem_address  = 15'h0010;
        Data_mem_dataIn   = 32'hDEADBEEF;
        repeat (2) @(posedge brq_clk);
        @(negedge brq_clk);
        Data_mem_write_en = 1'b0;
        brq_rst = 1'b1;
        ld(3'b010, 15'h0010); chk("rst_store_blocked", Data_mem_dataOut, 32'h01020304);
        chk("post_rst_err", {31'b0, dmem_err}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
